// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the two-requester ALU sharing block:
// op encodings, FSM state encoding and the default datapath width.
package alu_share_arb_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/alu_share_arb_alu32_core.sv
// Purely combinational ALU: bitwise logic, add/sub with signed overflow,
// logical right shift of B by A[4:0] and signed set-less-than.
module alu32_core
    import alu_share_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             ovf
);

    logic [WIDTH-1:0] and_bits;
    logic [WIDTH-1:0] or_bits;
    logic [WIDTH-1:0] xor_bits;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] srl_res;
    logic             slt_bit;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_logic
            assign and_bits[gi] = a[gi] & b[gi];
            assign or_bits[gi]  = a[gi] | b[gi];
            assign xor_bits[gi] = a[gi] ^ b[gi];
        end
    endgenerate

    assign sum     = a + b;
    assign diff    = a - b;
    assign srl_res = b >> a[4:0];
    assign slt_bit = $signed(a) < $signed(b);

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (op)
            ALU_AND: res = and_bits;
            ALU_OR:  res = or_bits;
            ALU_ADD: begin
                res = sum;
                ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_XOR: res = xor_bits;
            ALU_NOR: res = ~or_bits;
            ALU_SRL: res = srl_res;
            ALU_SUB: begin
                res = diff;
                ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SLT: res = {{(WIDTH-1){1'b0}}, slt_bit};
            default: res = '0;
        endcase
    end

    assign zero = (res == '0);

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one registered ALU between two requesters.
// Sequence per operation: IDLE (grant) -> EXEC (compute) -> RESP (hold result).
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter bit RR_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2:0]       op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [2:0]       op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             ovf,
    output logic             busy
);

    state_t           state_reg, state_next;
    logic             owner_reg;
    logic             ptr_reg;
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic             zero_reg;
    logic             ovf_reg;

    logic             win;
    logic             accept;
    logic             resp_done;
    logic [WIDTH-1:0] alu_res;
    logic             alu_zero;
    logic             alu_ovf;

    // A lone requester always wins; the pointer only breaks ties.
    assign win = (req_valid == 2'b11) ? ptr_reg : req_valid[1];

    alu32_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op   (op_reg),
        .a    (a_reg),
        .b    (b_reg),
        .res  (alu_res),
        .zero (alu_zero),
        .ovf  (alu_ovf)
    );

    always_comb begin
        state_next = state_reg;
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        accept     = 1'b0;
        resp_done  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req_valid) begin
                    req_ready[win] = 1'b1;
                    accept         = 1'b1;
                    state_next     = EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                resp_valid[owner_reg] = 1'b1;
                if (resp_ready[owner_reg]) begin
                    resp_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            owner_reg <= 1'b0;
            ptr_reg   <= RR_INIT;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            zero_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                owner_reg <= win;
                op_reg    <= win ? op1 : op0;
                a_reg     <= win ? a1 : a0;
                b_reg     <= win ? b1 : b0;
            end
            if (state_reg == EXEC) begin
                res_reg  <= alu_res;
                zero_reg <= alu_zero;
                ovf_reg  <= alu_ovf;
            end
            // Hand priority to the other requester once a result is taken.
            if (resp_done) begin
                ptr_reg <= ~owner_reg;
            end
        end
    end

    assign res  = res_reg;
    assign zero = zero_reg;
    assign ovf  = ovf_reg;
    assign busy = (state_reg != IDLE);

endmodule
